// File: rtl/irq_req_latch_pkg.sv
// nd_irq_pkg: shared constants, FSM state type and priority encoder for the IRQ capture stage
package nd_irq_pkg;

    localparam int IRQ_CHANNELS = 4;
    localparam int LEVEL_W      = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_REL = 2'd2
    } irq_state_t;

    // Highest set index wins; returns 0 when nothing is set.
    function automatic logic [LEVEL_W-1:0] prio_enc(input logic [IRQ_CHANNELS-1:0] v);
        logic [LEVEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < IRQ_CHANNELS; i++)
            if (v[i]) r = LEVEL_W'(i);
        return r;
    endfunction

endpackage

// File: rtl/irq_req_latch_sync.sv
// irq_sync: one-bit synchroniser chain for an asynchronous request line
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sysclk,
    input  logic sys_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw line through the flop chain; the last stage is safe to use.
    always_ff @(posedge sysclk) begin
        if (sys_rst) r_chain <= '0;
        else         r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/irq_req_latch.sv
// irq_req_latch: four-channel interrupt capture, masking and req/ack presentation to the microsequencer
module irq_req_latch
    import nd_irq_pkg::*;
#(
    parameter int                      SYNC_STAGES = 2,
    parameter logic [IRQ_CHANNELS-1:0] LEVEL_MODE  = 4'b0000
) (
    input  logic                    sysclk,
    input  logic                    sys_rst,
    input  logic [IRQ_CHANNELS-1:0] irq_in,
    input  logic                    mask_we,
    input  logic [IRQ_CHANNELS-1:0] mask_data,
    input  logic                    ack,
    output logic [IRQ_CHANNELS-1:0] pending,
    output logic [IRQ_CHANNELS-1:0] mask,
    output logic                    irq_req,
    output logic [LEVEL_W-1:0]      irq_level
);

    logic [IRQ_CHANNELS-1:0] w_sync;
    logic [IRQ_CHANNELS-1:0] w_rise;
    logic [IRQ_CHANNELS-1:0] w_clr;
    logic [IRQ_CHANNELS-1:0] w_arb;
    logic                    w_take;
    irq_state_t              w_next_state;

    logic [IRQ_CHANNELS-1:0] r_d;
    logic [IRQ_CHANNELS-1:0] r_pending;
    logic [IRQ_CHANNELS-1:0] r_mask;
    logic [LEVEL_W-1:0]      r_level;
    irq_state_t              r_state;

    for (genvar g = 0; g < IRQ_CHANNELS; g++) begin : g_sync
        irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .sysclk  (sysclk),
            .sys_rst (sys_rst),
            .i_d     (irq_in[g]),
            .o_q     (w_sync[g])
        );
    end

    assign w_rise = w_sync & ~r_d;
    assign w_arb  = r_pending & r_mask;
    assign w_take = (r_state == REQ) && ack;
    assign w_clr  = w_take ? (IRQ_CHANNELS'(1) << r_level) : '0;

    // Track previous synchronised value, mask register, and pending bits (a new rise beats an ack clear).
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_d       <= '0;
            r_mask    <= '0;
            r_pending <= '0;
        end else begin
            r_d       <= w_sync;
            r_mask    <= mask_we ? mask_data : r_mask;
            r_pending <= (LEVEL_MODE & w_sync) | (~LEVEL_MODE & (w_rise | (r_pending & ~w_clr)));
        end
    end

    // State register; the granted level is frozen when leaving IDLE.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_state <= IDLE;
            r_level <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && |w_arb) r_level <= prio_enc(w_arb);
        end
    end

    // Handshake sequencing: request on any enabled pending bit, wait for ack, then for its release.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     w_next_state = |w_arb ? REQ : IDLE;
            REQ:      w_next_state = ack ? WAIT_REL : REQ;
            WAIT_REL: w_next_state = ack ? WAIT_REL : IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    assign pending   = r_pending;
    assign mask      = r_mask;
    assign irq_req   = (r_state == REQ);
    assign irq_level = r_level;

endmodule

// File: tb/tb_irq_req_latch.sv
// tb_irq_req_latch: scoreboard bench with a history-based reference model of the IRQ capture stage
module tb_irq_req_latch;

    localparam logic [3:0] LM = 4'b0001;

    logic       sysclk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [3:0] irq_in = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_data = '0;
    logic       ack = 1'b0;
    logic [3:0] pending;
    logic [3:0] mask;
    logic       irq_req;
    logic [1:0] irq_level;

    always #5 sysclk = ~sysclk;

    irq_req_latch #(.SYNC_STAGES(2), .LEVEL_MODE(LM)) dut (
        .sysclk    (sysclk),
        .sys_rst   (sys_rst),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_data (mask_data),
        .ack       (ack),
        .pending   (pending),
        .mask      (mask),
        .irq_req   (irq_req),
        .irq_level (irq_level)
    );

    typedef struct {
        logic [3:0] pend;
        logic [3:0] msk;
        logic       req;
        logic [1:0] lvl;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: h[j] is irq_in as sampled (j+1) edges before the edge being modelled.
    logic [3:0] h [3];
    logic [3:0] m_pend = '0;
    logic [3:0] m_mask = '0;
    int         m_phase = 0;
    int         m_lvl = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp_v);
        end
    endtask

    // One clock cycle: drive inputs for the next edge and predict the state after it.
    task automatic cyc(input logic [3:0] irq, input logic mw, input logic [3:0] md,
                       input logic a, input logic r);
        exp_t       e;
        logic [3:0] rise;
        logic [3:0] sel;
        logic [3:0] newp;
        @(negedge sysclk);
        irq_in = irq; mask_we = mw; mask_data = md; ack = a; sys_rst = r;
        if (r) begin
            h[0] = '0; h[1] = '0; h[2] = '0;
            m_pend = '0; m_mask = '0; m_phase = 0; m_lvl = 0;
        end else begin
            rise = h[1] & ~h[2];
            for (int i = 0; i < 4; i++)
                newp[i] = LM[i] ? h[1][i] : (rise[i] | (m_pend[i] & !(m_phase == 1 && a && m_lvl == i)));
            sel = m_pend & m_mask;
            if (m_phase == 0) begin
                if (sel != 0) begin
                    for (int i = 0; i < 4; i++) if (sel[i]) m_lvl = i;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (a) m_phase = 2;
            end else if (!a) m_phase = 0;
            if (mw) m_mask = md;
            m_pend = newp;
            h[2] = h[1]; h[1] = h[0]; h[0] = irq;
        end
        e.pend = m_pend;
        e.msk  = m_mask;
        e.req  = (m_phase == 1);
        e.lvl  = 2'(m_lvl);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    function automatic logic pick_ack();
        if (m_phase == 1) return ($urandom_range(2) == 0);
        if (m_phase == 2) return ($urandom_range(1) == 0);
        return ($urandom_range(7) == 0);
    endfunction

    // Monitor: compare every registered output just after each edge with the predicted values.
    always @(posedge sysclk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pending", pending, e.pend);
            chk("mask", mask, e.msk);
            chk("irq_req", {3'b0, irq_req}, {3'b0, e.req});
            chk("irq_level", {2'b0, irq_level}, {2'b0, e.lvl});
        end
    end

    initial begin
        h[0] = '0; h[1] = '0; h[2] = '0;
        cyc(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        cyc(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        cyc(4'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
        idle(3);
        // single pulse on channel 2
        cyc(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(4);
        cyc(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        cyc(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        idle(3);
        // simultaneous channels 3 and 1
        cyc(4'b1010, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(5);
        for (int k = 0; k < 2; k++) begin
            cyc(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
            cyc(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
            idle(3);
        end
        // masked channel stays pending, request appears after mask write
        cyc(4'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        cyc(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(5);
        cyc(4'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
        idle(3);
        cyc(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        idle(3);
        cyc(4'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
        // new rise on channel 3 lands on the edge its ack clears it
        cyc(4'b1000, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(5);
        cyc(4'b1000, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(1);
        cyc(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        cyc(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        idle(4);
        cyc(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        idle(3);
        // level channel 0 held high through several handshakes, then dropped
        for (int k = 0; k < 14; k++) cyc(4'b0001, 1'b0, 4'b0, pick_ack(), 1'b0);
        idle(1);
        cyc(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        idle(4);
        // reset while in REQ with ack high
        cyc(4'b0010, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(4);
        cyc(4'b0, 1'b0, 4'b0, 1'b1, 1'b1);
        idle(5);
        cyc(4'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
        idle(3);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] rq;
            for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(5) == 0);
            cyc(rq, ($urandom_range(9) == 0), 4'($urandom), pick_ack(), ($urandom_range(199) == 0));
        end
        idle(2);
        @(posedge sysclk);
        #2;
        chk("scoreboard_drained", 4'(q.size() > 0 ? 1 : 0), 4'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_req_latch.md
# irq_req_latch

Four-channel interrupt request capture stage for the ND-120 CPU board. It synchronises asynchronous request lines and latches edges into pending bits. It masks them, presents the highest-priority unmasked request to the microsequencer with a req/ack handshake, and clears the serviced bit. `pending[3:0]` feeds the downstream 4-input NOR gate stage (no bubbles), which produces the active-high "no interrupt pending" term.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth per channel, minimum 2.
- `LEVEL_MODE`, default 4'b0000: per channel, 1 = level-sensitive, 0 = rising-edge latched.
- `sysclk` in 1: system clock; all state updates on its rising edge.
- `sys_rst` in 1: reset, synchronous, active-high.
- `irq_in` in 4: asynchronous request lines, active-high.
- `mask_we` in 1: load `mask_data` into mask register.
- `mask_data` in 4: new mask; 1 = channel enabled.
- `ack` in 1: acknowledge from microsequencer, level.
- `pending` out 4: latched request bits, unmasked (to the NOR stage).
- `mask` out 4: current mask register.
- `irq_req` out 1: interrupt request to the microsequencer.
- `irq_level` out 2: channel being requested; 3 = highest priority.

## Operation
- Sync: each `irq_in[i]` passes through a `SYNC_STAGES` flop chain. `d[i]` holds the previous synchronised value. Rise = sync & ~d.
- Edge channel: pending set on rise; cleared on ack-capture of that channel. Set and clear in the same cycle: set wins.
- Level channel: pending = synchronised value every cycle; ack has no effect on it.
- Masked pending bits still latch and stay visible on `pending`; the mask only gates arbitration.
- `mask_we` takes effect next edge and may happen in any state.
- FSM states:
  - IDLE: `irq_req`=0. If (pending & mask) != 0, latch `irq_level` = highest set index, then go to REQ.
  - REQ: `irq_req`=1, `irq_level` frozen. Mask changes do not withdraw the request. When `ack`=1: clear pending[irq_level] (edge channels), then go to WAIT_REL.
  - WAIT_REL: `irq_req`=0. When `ack`=0, go to IDLE.
- `ack` in IDLE is ignored.
- Reset values: all sync flops, `d`, `pending`, `mask`, `irq_level` = 0; `irq_req` = 0; state IDLE. Reset in any state (including REQ with `ack` high) returns to IDLE next edge and drops any in-flight request.

## Timing
- `irq_in[i]` first sampled high at edge N:
  - `pending[i]` high after edge N+SYNC_STAGES.
  - `irq_req` high after edge N+SYNC_STAGES+1 (N+3 at default), provided the channel is enabled and the FSM is IDLE.
- `ack` sampled high at edge M in REQ: `irq_req` low and pending bit cleared after M.
- Next request is possible no earlier than one edge after `ack` is seen low.
- `irq_in` pulses shorter than one `sysclk` period may be lost. Pulses of at least one period are guaranteed to be latched.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package `nd_irq_pkg`:
  - `IRQ_CHANNELS` = 4.
  - FSM state enum `irq_state_t` {IDLE, REQ, WAIT_REL}.
  - Priority-encode function (highest index wins).
- Sub-module `irq_sync`: one-bit `SYNC_STAGES` flop chain with sync reset; instantiated four times.

## Test plan
- Reset, mask=4'b1111, pulse `irq_in`=4'b0100 for 1 cycle: `pending`=4'b0100 after N+2; `irq_req`=1, `irq_level`=2 after N+3. Assert `ack`: `pending`=0, `irq_req`=0; deassert `ack`: FSM returns to IDLE.
- `irq_in`=4'b1010 simultaneously: first grant `irq_level`=3; after ack/release, second grant `irq_level`=1.
- mask=4'b0001, pulse channel 2: `pending`=4'b0100, `irq_req` stays 0. Then write mask=4'b0100: `irq_req`=1 with `irq_level`=2 two edges later.
- New rising edge on channel 3 in the same cycle its ack clears it: `pending[3]` stays 1, and a second request for level 3 follows after release.
- LEVEL_MODE=4'b0001, hold `irq_in[0]` high through ack: `pending[0]` stays 1 and re-requests after WAIT_REL. Drop `irq_in[0]`: `pending[0]`=0 after 2 edges.
- Assert `sys_rst` while in REQ with `ack` high: next edge all outputs are 0 and state is IDLE. No request is issued until a new edge arrives.
